// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage.
// Holds the default datapath width, the NOP value presented when nothing
// is valid, the default reset fetch address and the prefetch-queue entry type.
package if_pkg;

    localparam int IF_XLEN = 32;

    localparam logic [IF_XLEN-1:0] IF_NOP      = 32'h0000_0000;
    localparam logic [IF_XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

    // One prefetch-queue entry: fetch address in the upper half, instruction in the lower half.
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue for the fetch stage.
// Power-of-two depth circular buffer with a synchronous flush, simultaneous
// push/pop (including push into a full queue when the head pops the same edge),
// and full/empty flags plus an occupancy count.
module if_prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;

    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop: pop needs data, push needs room or a concurrent pop.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Status flags and head are decoded straight from registered state.
    always_comb begin
        empty     = (count_r == {CW{1'b0}});
        full      = (count_r == CNT_DEPTH);
        count     = count_r;
        head_data = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy bookkeeping; flush empties the queue at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; a flush suppresses the write so no stale entry lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage.
// Issues in-order instruction-memory requests, queues responses with their
// fetch address, and delivers them downstream with validF/instructionF/PCF
// (PCF = fetch address + 4). A taken branch flushes the queue, redirects the
// fetch PC and discards every response still in flight.
// Optional feature: define IF_PERF_CNT_EN to add the fetchCount/flushCount
// performance counters.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int             N        = IF_XLEN,
    parameter int             DEPTH    = 4,
    parameter logic [N-1:0]   RESET_PC = N'(IF_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [N-1:0]     imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [N-1:0]     imem_rdata,
    input  logic             branchTakenF,
    input  logic [N-1:0]     branchAdderF,
    input  logic             freezeF,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]      fetchCount,
    output logic [31:0]      flushCount,
`endif
    output logic             validF,
    output logic [N-1:0]     instructionF,
    output logic [N-1:0]     PCF
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW:0]   DEPTH_C    = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [N-1:0]  PC_STEP    = N'(3'd4);
    localparam logic [N-1:0]  ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

    logic [N-1:0]    fetch_pc_r;
    logic [N-1:0]    resp_pc_r;
    logic [CW-1:0]   out_cnt_r;
    logic [CW-1:0]   disc_cnt_r;

    logic [CW-1:0]   fifo_count_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [2*N-1:0]  fifo_head_s;

    logic            room_s;
    logic            grant_s;
    logic            resp_discard_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   rv_cnt_s;
    logic [N-1:0]    branch_target_s;

    // Request/accept decisions for this cycle. The reset gate keeps the
    // request low while rst is asserted yet lets it rise the first cycle after.
    always_comb begin
        room_s          = ({1'b0, fifo_count_s} + {1'b0, out_cnt_r}) < DEPTH_C;
        imem_req        = rst & room_s & ~branchTakenF;
        imem_addr       = fetch_pc_r;
        grant_s         = imem_req & imem_gnt;
        rv_cnt_s        = {{(CW-1){1'b0}}, imem_rvalid};
        resp_discard_s  = branchTakenF | (disc_cnt_r != {CW{1'b0}});
        push_s          = imem_rvalid & ~resp_discard_s & (~fifo_full_s | pop_s);
        pop_s           = ~fifo_empty_s & ~freezeF & ~branchTakenF;
        branch_target_s = branchAdderF & ALIGN_MASK;
    end

    // Fetch PC, response PC and in-flight/discard counters; a branch wins over all else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            out_cnt_r  <= {CW{1'b0}};
            disc_cnt_r <= {CW{1'b0}};
        end else if (branchTakenF) begin
            fetch_pc_r <= branch_target_s;
            resp_pc_r  <= branch_target_s;
            out_cnt_r  <= out_cnt_r - rv_cnt_s;
            disc_cnt_r <= out_cnt_r - rv_cnt_s;
        end else begin
            if (grant_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + PC_STEP;
            end else begin
                resp_pc_r <= resp_pc_r;
            end
            case ({grant_s, imem_rvalid})
                2'b10:   out_cnt_r <= out_cnt_r + CNT_ONE;
                2'b01:   out_cnt_r <= out_cnt_r - CNT_ONE;
                default: out_cnt_r <= out_cnt_r;
            endcase
            if (imem_rvalid && (disc_cnt_r != {CW{1'b0}})) begin
                disc_cnt_r <= disc_cnt_r - CNT_ONE;
            end else begin
                disc_cnt_r <= disc_cnt_r;
            end
        end
    end

    if_prefetch_fifo #(
        .WIDTH (2*N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (branchTakenF),
        .push      (push_s),
        .push_data ({resp_pc_r, imem_rdata}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Downstream view of the queue head; NOP and zero PC while nothing is valid.
    always_comb begin
        validF = ~fifo_empty_s;
        if (validF) begin
            instructionF = fifo_head_s[N-1:0];
            PCF          = fifo_head_s[2*N-1:N] + PC_STEP;
        end else begin
            instructionF = N'(IF_NOP);
            PCF          = {N{1'b0}};
        end
    end

`ifdef IF_PERF_CNT_EN
    // Wrapping counts of instructions handed downstream and redirects taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchCount <= 32'd0;
            flushCount <= 32'd0;
        end else begin
            if (pop_s) begin
                fetchCount <= fetchCount + 32'd1;
            end else begin
                fetchCount <= fetchCount;
            end
            if (branchTakenF) begin
                flushCount <= flushCount + 32'd1;
            end else begin
                flushCount <= flushCount;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage (N=32, DEPTH=4, RESET_PC=0).
// A behavioural memory answers granted requests in order one cycle later
// (or later while held); a scoreboard of expected {PCF, instruction} entries
// is filled from non-discarded responses and compared at the DUT outputs.
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branchTakenF;
    logic [31:0] branchAdderF;
    logic        freezeF;
    logic        validF;
    logic [31:0] instructionF;
    logic [31:0] PCF;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCount;
    logic [31:0] flushCount;
`endif

    always #5 clk = ~clk;

    if_prefetch_stage #(
        .N        (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .branchTakenF (branchTakenF),
        .branchAdderF (branchAdderF),
        .freezeF      (freezeF),
`ifdef IF_PERF_CNT_EN
        .fetchCount   (fetchCount),
        .flushCount   (flushCount),
`endif
        .validF       (validF),
        .instructionF (instructionF),
        .PCF          (PCF)
    );

    typedef struct { logic [31:0] addr; bit keep; } mreq_t;
    typedef struct { logic [31:0] pcf; logic [31:0] instr; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] exp_pc;
    bit          mem_hold;
    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    int          flushes  = 0;
    logic [31:0] held_pcf;
    logic [31:0] held_instr;
    int          budget;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic chk_perf();
        #1;
        chk("fetchCount", fetchCount, pops);
        chk("flushCount", flushCount, flushes);
    endtask
`endif

    // One clock cycle: check outputs against the model, advance the model
    // through the edge, then let the memory drive this cycle's response.
    task automatic tick();
        logic        exp_req;
        logic [31:0] ga;
        bit          g;
        bit          pop;
        mreq_t       h;
        exp_t        e;
        #1;
        if (rst) begin
            exp_req = ((exp_q.size() + mem_q.size()) < 4) && !branchTakenF;
            ga      = exp_pc;
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, ga);
            chk("validF", 32'(validF), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("PCF", PCF, exp_q[0].pcf);
                chk("instructionF", instructionF, exp_q[0].instr);
            end else begin
                chk("PCF_idle", PCF, 32'h0);
                chk("instr_idle", instructionF, 32'h0);
            end
            g   = exp_req && imem_gnt;
            pop = (exp_q.size() != 0) && !freezeF && !branchTakenF;
            if (branchTakenF) begin
                flushes++;
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].keep = 1'b0;
                exp_pc = {branchAdderF[31:2], 2'b00};
            end else begin
                if (pop) begin
                    pops++;
                    void'(exp_q.pop_front());
                end
                if (g) exp_pc = exp_pc + 32'd4;
            end
            if (imem_rvalid && mem_q.size() != 0) begin
                h = mem_q.pop_front();
                if (h.keep) begin
                    e.pcf   = h.addr + 32'd4;
                    e.instr = mem_data(h.addr);
                    exp_q.push_back(e);
                end
            end
            if (g) begin
                h.addr = ga;
                h.keep = 1'b1;
                mem_q.push_back(h);
            end
        end else begin
            chk("rst_imem_req", 32'(imem_req), 32'h0);
            chk("rst_validF", 32'(validF), 32'h0);
            chk("rst_instructionF", instructionF, 32'h0);
            chk("rst_PCF", PCF, 32'h0);
            mem_q.delete();
            exp_q.delete();
            exp_pc  = 32'h0;
            pops    = 0;
            flushes = 0;
        end
        @(posedge clk);
        #1;
        if (rst && !mem_hold && mem_q.size() != 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        branchTakenF = 1'b0;
        branchAdderF = 32'h0;
        freezeF      = 1'b0;
        mem_hold     = 1'b0;
        exp_pc       = 32'h0;
        @(negedge clk);
        tick();
        tick();

        // Reset release with an always-granting, one-cycle memory.
        imem_gnt = 1'b1;
        rst      = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        tick();
        tick();
        #1;
        chk("c2_validF", 32'(validF), 32'h1);
        chk("c2_PCF", PCF, 32'h4);
        chk("c2_instr", instructionF, mem_data(32'h0));
        tick();
        #1;
        chk("c3_PCF", PCF, 32'h8);
        tick();
        #1;
        chk("c4_PCF", PCF, 32'hC);
        repeat (6) tick();

        // Downstream freeze: outputs hold and fetching stops at DEPTH.
        freezeF = 1'b1;
        #1;
        held_pcf   = PCF;
        held_instr = instructionF;
        repeat (6) begin
            tick();
            #1;
            chk("frz_validF", 32'(validF), 32'h1);
            chk("frz_PCF_hold", PCF, held_pcf);
            chk("frz_instr_hold", instructionF, held_instr);
        end
        chk("frz_req_dropped", 32'(imem_req), 32'h0);
        freezeF = 1'b0;
        repeat (8) tick();

        // Branch together with freeze on a full queue.
        freezeF = 1'b1;
        repeat (6) tick();
        chk("full_req_dropped", 32'(imem_req), 32'h0);
        branchTakenF = 1'b1;
        branchAdderF = 32'h0000_0200;
        tick();
        branchTakenF = 1'b0;
        freezeF      = 1'b0;
        #1;
        chk("flush_validF", 32'(validF), 32'h0);
        chk("flush_addr", imem_addr, 32'h0000_0200);
        repeat (6) tick();

        // Branch to 0x103 with two requests still outstanding.
        imem_gnt = 1'b0;
        repeat (5) tick();
        mem_hold = 1'b1;
        imem_gnt = 1'b1;
        tick();
        tick();
        branchTakenF = 1'b1;
        branchAdderF = 32'h0000_0103;
        tick();
        branchTakenF = 1'b0;
        mem_hold     = 1'b0;
        #1;
        chk("br_req", 32'(imem_req), 32'h1);
        chk("br_addr", imem_addr, 32'h0000_0100);
        budget = 12;
        while (!validF && budget > 0) begin
            tick();
            budget--;
        end
        chk("br_wait_budget", 32'(validF), 32'h1);
        chk("br_first_PCF", PCF, 32'h0000_0104);
        chk("br_first_instr", instructionF, mem_data(32'h0000_0100));
        repeat (4) tick();

        // Fetch PC wrap-around; the response in the branch cycle is discarded.
        branchTakenF = 1'b1;
        branchAdderF = 32'hFFFF_FFFE;
        tick();
        branchTakenF = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        repeat (6) tick();
`ifdef IF_PERF_CNT_EN
        chk_perf();
`endif

        // Mixed grant/freeze/hold/branch traffic.
        repeat (60) begin
            imem_gnt     = ($urandom_range(0, 3) != 0);
            freezeF      = ($urandom_range(0, 3) == 0);
            mem_hold     = ($urandom_range(0, 4) == 0);
            branchTakenF = ($urandom_range(0, 11) == 0);
            branchAdderF = $urandom;
            tick();
        end
        branchTakenF = 1'b0;
        freezeF      = 1'b0;
        mem_hold     = 1'b0;
        imem_gnt     = 1'b1;
        repeat (6) tick();
`ifdef IF_PERF_CNT_EN
        chk_perf();
`endif

        // Reset in the middle of traffic; memory is reset alongside.
        rst = 1'b0;
        tick();
`ifdef IF_PERF_CNT_EN
        chk_perf();
`endif
        tick();
        rst = 1'b1;
        #1;
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        repeat (8) tick();

        // Drain and confirm the stage goes idle.
        imem_gnt = 1'b0;
        repeat (8) tick();
        #1;
        chk("drain_validF", 32'(validF), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL provide parameter N, default 32, address/instruction width.
REQ-002 SHALL provide parameter DEPTH, default 4, prefetch-queue entries; power of two, >= 2.
REQ-003 SHALL provide parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL provide clk  input  1  sole clock, rising edge.
REQ-005 SHALL provide rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide imem_req  output  1  fetch request valid.
REQ-007 SHALL provide imem_addr  output  N  fetch address.
REQ-008 SHALL provide imem_gnt  input  1  request accepted this cycle.
REQ-009 SHALL provide imem_rvalid  input  1  response data valid.
REQ-010 SHALL provide imem_rdata  input  N  response instruction.
REQ-011 SHALL provide branchTakenF  input  1  redirect request.
REQ-012 SHALL provide branchAdderF  input  N  redirect target.
REQ-013 SHALL provide freezeF  input  1  downstream stall.
REQ-014 SHALL provide validF  output  1  instructionF/PCF valid.
REQ-015 SHALL provide instructionF  output  N  delivered instruction.
REQ-016 SHALL provide PCF  output  N  delivered instruction address + 4.

Function
REQ-017 Memory responses SHALL be in order, one per granted request, no earlier than the cycle after grant.
REQ-018 imem_req SHALL be 1 only when queue occupancy + outstanding requests < DEPTH and branchTakenF = 0.
REQ-019 imem_addr SHALL equal the fetch PC; on req & gnt the fetch PC SHALL advance by 4, modulo 2^N (wrap-around).
REQ-020 Each non-discarded response SHALL be pushed with its fetch address; validF SHALL rise no earlier than the cycle after imem_rvalid (no bypass); minimum request-to-validF latency is 2 cycles.
REQ-021 validF SHALL be 1 whenever the queue is non-empty; the head SHALL pop at the clock edge when validF = 1 and freezeF = 0.
REQ-022 With freezeF = 1, validF, instructionF and PCF SHALL hold; fetching SHALL continue until the queue plus outstanding count reaches DEPTH.
REQ-023 When validF = 0, instructionF and PCF SHALL be 0.
REQ-024 branchTakenF = 1 SHALL, at the edge: clear the queue, load the fetch PC with branchAdderF with bits [1:0] forced to 0, and mark all outstanding responses for discard; it SHALL override freezeF.
REQ-025 Discarded responses SHALL never enter the queue; responses arriving in the branch cycle itself SHALL be discarded.
REQ-026 A response arriving in the same cycle as a pop with a full queue SHALL be accepted (simultaneous push/pop).
REQ-027 Outstanding and discard counters SHALL be clog2(DEPTH)+1 bits wide and never overflow, guaranteed by REQ-018.

Reset
REQ-028 While rst = 0: fetch PC = RESET_PC, queue empty, all counters 0, imem_req = 0, validF = 0, instructionF = 0, PCF = 0.
REQ-029 Reset asserted mid-transaction SHALL drop all outstanding requests; responses after release SHALL be ignored only if granted before reset, so the memory SHALL be reset together with this block.
REQ-030 The first request SHALL be issued in the first cycle after rst deasserts, at RESET_PC.

Configuration
REQ-031 Macro IF_PERF_CNT_EN, when defined, SHALL add outputs fetchCount (32, instructions popped) and flushCount (32, redirects taken), both wrapping and reset to 0.
REQ-032 Without IF_PERF_CNT_EN the ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-033 Package if_pkg SHALL hold the default width, NOP value 0, default RESET_PC and the queue-entry typedef {pc, instr}.
REQ-034 The queue SHALL be the sub-module if_prefetch_fifo (synchronous flush, simultaneous push/pop, full/empty flags).

Verification
REQ-035 Reset release, gnt always 1, 1-cycle memory: validF at cycle 2, PCF = 4, 8, 12 on successive cycles, instructions in order.
REQ-036 freezeF held 6 cycles with DEPTH = 4: outputs stable, imem_req drops after 4 requests in flight/queued, resumes on release with no loss.
REQ-037 Branch to 0x103 with 2 requests outstanding: both responses discarded, next request addr 0x100, first validF shows PCF = 0x104.
REQ-038 Branch and freezeF together with full queue: queue flushed, validF = 0 next cycle.
REQ-039 Fetch PC at 0xFFFFFFFC granted: next imem_addr = 0x0.
REQ-040 With IF_PERF_CNT_EN, 10 pops and 3 branches: fetchCount = 10, flushCount = 3; rst low mid-run: both return to 0.
